// File: rtl/caliptra_apb_init_pkg.sv
// Shared types and defaults for the Caliptra APB initiator.
package caliptra_apb_init_pkg;

   // Native APB data width used for the buffered response record.
   localparam int APB_DATA_W = 32;

   // Default ACCESS-phase cycle limit before a transfer is abandoned.
   localparam int TIMEOUT_CYC_DFLT = 1024;

   // Default protection attributes driven on PPROT.
   localparam logic [2:0] PPROT_DFLT_VAL = 3'b000;

   // Width of the debug transfer/error counters.
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_init_state_e;

   // Response held for the host until it is accepted.
   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_init_rsp_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             inc);
      logic [CNT_W-1:0] result;
      result = value;
      if (inc && (value != {CNT_W{1'b1}})) begin
         result = value + 1'b1;
      end
      return result;
   endfunction

endpackage

// File: rtl/caliptra_apb_initiator.sv
// APB requester bridging a single-outstanding host request channel onto the
// Caliptra APB responder port, with an access timeout and debug counters.
module caliptra_apb_initiator
   import caliptra_apb_init_pkg::*;
#(
   parameter int         ADDR_W      = 32,
   parameter int         DATA_W      = APB_DATA_W,
   parameter int         USER_W      = 32,
   parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DFLT,
   parameter logic [2:0] PPROT_DFLT  = PPROT_DFLT_VAL
) (
   input  logic              core_clk,
   input  logic              core_rst,

   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [USER_W-1:0] req_user,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,

   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   output logic [2:0]        PPROT,
   output logic [USER_W-1:0] PAUSER,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,

   output logic [CNT_W-1:0]  cnt_xfer,
   output logic [CNT_W-1:0]  cnt_err
);

   // Last ACCESS cycle index; the counter starts at zero on the first ACCESS cycle.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   apb_init_state_e state;
   apb_init_state_e state_next;
   apb_init_rsp_t   rsp_q;
   logic [15:0]     to_cnt;
   logic            to_hit;
   logic            req_fire;
   logic            rsp_fire;

   assign PPROT       = PPROT_DFLT;
   assign rsp_rdata   = DATA_W'(rsp_q.rdata);
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

   assign to_hit   = (to_cnt == TO_LAST);
   assign req_fire = req_valid && req_ready;
   assign rsp_fire = rsp_valid && rsp_ready;

   // State register; reset abandons any transfer in flight without a response.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection and APB/host handshake decode from the current state.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      PSEL       = 1'b0;
      PENABLE    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !core_rst;
            if (req_valid && !core_rst) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            PSEL       = 1'b1;
            state_next = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            if (PREADY || to_hit) begin
               state_next = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // APB address/control/data flops; loaded only on acceptance so they stay stable
   // through SETUP and ACCESS and keep their last value afterwards.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         PAUSER <= '0;
      end else if (req_fire) begin
         PADDR  <= req_addr;
         PWRITE <= req_write;
         PWDATA <= req_wdata;
         PAUSER <= req_user;
      end
   end

   // ACCESS-phase cycle counter; cleared in every other state so each transfer starts fresh.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         to_cnt <= '0;
      end else if (state == ACCESS) begin
         to_cnt <= to_cnt + 16'd1;
      end else begin
         to_cnt <= '0;
      end
   end

   // Response capture at the end of ACCESS; PREADY takes priority over the timeout.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         rsp_q <= '0;
      end else if (state == ACCESS) begin
         if (PREADY) begin
            rsp_q.rdata   <= PWRITE ? '0 : APB_DATA_W'(PRDATA);
            rsp_q.err     <= PSLVERR;
            rsp_q.timeout <= 1'b0;
         end else if (to_hit) begin
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
         end
      end
   end

   // Saturating debug counters, bumped when the host takes the response.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         cnt_xfer <= '0;
         cnt_err  <= '0;
      end else if (rsp_fire) begin
         cnt_xfer <= sat_inc(cnt_xfer, 1'b1);
         cnt_err  <= sat_inc(cnt_err, rsp_q.err);
      end
   end

endmodule

// File: tb/tb_caliptra_apb_initiator.sv
// Randomized, self-checking bench for the Caliptra APB initiator. A
// transaction-level model predicts the per-cycle phase of each transfer from
// its acceptance cycle and wait count; a directed prologue pins the model.
module tb_caliptra_apb_initiator;

   localparam int TO     = 8;
   localparam int N_CYC  = 4000;
   localparam int ND     = 6;

   logic        core_clk = 1'b0;
   logic        core_rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata, req_user;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [31:0] PADDR, PWDATA, PAUSER, PRDATA;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [2:0]  PPROT;
   logic [15:0] cnt_xfer, cnt_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model of the transfer in flight, described by when it was accepted.
   bit          busy;
   int          elapsed, k, w_cur, m_hold, cur_d, acc_cyc;
   bit          m_write, m_err, m_to, m_slv, rsp_seen;
   logic [31:0] m_addr, m_wdata, m_user, m_rdata, m_prd;
   int          m_xfer, m_errc;

   // Responder behaviour attached to the request currently being offered.
   int          o_w, o_hold, o_didx;
   logic [31:0] o_prd;
   bit          o_slv;

   int          d_next;
   bit          lit_done, rst_forced, rst_probe;

   // Directed prologue: write, slow read, error read, timeout, last-cycle ready, held response.
   bit          d_write [ND] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] d_addr  [ND] = '{32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44};
   logic [31:0] d_wdata [ND] = '{32'hA5A5_5A5A, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1111_2222};
   logic [31:0] d_user  [ND] = '{32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
   int          d_w     [ND] = '{0, 5, 1, 20, 7, 0};
   logic [31:0] d_prd   [ND] = '{32'h9999_9999, 32'h1234_5678, 32'hDEAD_BEEF, 32'h7777_7777, 32'hCAFE_F00D, 32'h5555_5555};
   bit          d_slv   [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   int          d_hold  [ND] = '{0, 0, 0, 0, 0, 10};
   int          d_lat   [ND] = '{3, 8, 4, 10, 10, 3};
   logic [31:0] d_rdata [ND] = '{32'h0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 32'hCAFE_F00D, 32'h0};
   bit          d_err   [ND] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   bit          d_to    [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   always #5 core_clk = ~core_clk;

   caliptra_apb_initiator #(
      .ADDR_W(32), .DATA_W(32), .USER_W(32), .TIMEOUT_CYC(TO), .PPROT_DFLT(3'b000)
   ) dut (
      .core_clk(core_clk), .core_rst(core_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_user(req_user),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PPROT(PPROT), .PAUSER(PAUSER),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .cnt_xfer(cnt_xfer), .cnt_err(cnt_err)
   );

   // One comparison: counts it, and reports it when the values differ.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Advance the model over the clock edge just taken, using the inputs of the cycle that ended.
   task automatic advanceModel();
      if (core_rst) begin
         busy    = 1'b0;
         m_xfer  = 0;
         m_errc  = 0;
         m_addr  = '0;
         m_wdata = '0;
         m_user  = '0;
      end else if (busy) begin
         if (elapsed >= 3 + k && rsp_ready) begin
            busy   = 1'b0;
            m_xfer = (m_xfer < 65535) ? m_xfer + 1 : 65535;
            m_errc = (m_errc < 65535) ? m_errc + int'(m_err) : 65535;
         end else begin
            elapsed++;
         end
      end else if (req_valid) begin
         busy     = 1'b1;
         elapsed  = 1;
         m_write  = req_write;
         m_addr   = req_addr;
         m_wdata  = req_wdata;
         m_user   = req_user;
         w_cur    = o_w;
         k        = (o_w < TO - 1) ? o_w : TO - 1;
         m_prd    = o_prd;
         m_slv    = o_slv;
         m_hold   = o_hold;
         cur_d    = o_didx;
         acc_cyc  = cyc - 1;
         rsp_seen = 1'b0;
         if (o_w <= TO - 1) begin
            m_rdata = req_write ? 32'h0 : o_prd;
            m_err   = o_slv;
            m_to    = 1'b0;
         end else begin
            m_rdata = 32'h0;
            m_err   = 1'b1;
            m_to    = 1'b1;
         end
      end
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic compareAll();
      bit exp_psel, exp_pen, exp_rv;
      exp_psel = busy && (elapsed <= 2 + k);
      exp_pen  = busy && (elapsed >= 2) && (elapsed <= 2 + k);
      exp_rv   = busy && (elapsed >= 3 + k);
      checkOutput("req_ready", 32'(req_ready), 32'(!busy && !core_rst));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      checkOutput("PSEL", 32'(PSEL), 32'(exp_psel));
      checkOutput("PENABLE", 32'(PENABLE), 32'(exp_pen));
      checkOutput("PADDR", PADDR, m_addr);
      checkOutput("PWDATA", PWDATA, m_wdata);
      checkOutput("PAUSER", PAUSER, m_user);
      checkOutput("PPROT", 32'(PPROT), 32'h0);
      checkOutput("cnt_xfer", 32'(cnt_xfer), 32'(m_xfer));
      checkOutput("cnt_err", 32'(cnt_err), 32'(m_errc));
      if (exp_psel) checkOutput("PWRITE", 32'(PWRITE), 32'(m_write));
      if (exp_rv) begin
         checkOutput("rsp_rdata", rsp_rdata, m_rdata);
         checkOutput("rsp_err", 32'(rsp_err), 32'(m_err));
         checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
      end
      if (busy && cur_d >= 0 && rsp_valid === 1'b1 && !rsp_seen) begin
         rsp_seen = 1'b1;
         checkOutput($sformatf("d%0d_latency", cur_d), 32'(cyc - acc_cyc), 32'(d_lat[cur_d]));
         checkOutput($sformatf("d%0d_rdata", cur_d), rsp_rdata, d_rdata[cur_d]);
         checkOutput($sformatf("d%0d_err", cur_d), 32'(rsp_err), 32'(d_err[cur_d]));
         checkOutput($sformatf("d%0d_timeout", cur_d), 32'(rsp_timeout), 32'(d_to[cur_d]));
      end
      if (d_next == ND && !busy && !lit_done && cyc > 4) begin
         lit_done = 1'b1;
         checkOutput("directed_cnt_xfer", 32'(cnt_xfer), 32'd6);
         checkOutput("directed_cnt_err", 32'(cnt_err), 32'd3);
      end
      if (rst_probe) begin
         rst_probe = 1'b0;
         checkOutput("midrst_PSEL", 32'(PSEL), 32'h0);
         checkOutput("midrst_PENABLE", 32'(PENABLE), 32'h0);
         checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
         checkOutput("midrst_cnt_xfer", 32'(cnt_xfer), 32'h0);
      end
   endtask

   // Choose the inputs for the current cycle: reset, host request, host ready, APB responder.
   task automatic applyStimulus();
      int  r;
      bit  in_access;
      core_rst = 1'b0;
      if (cyc <= 3) begin
         core_rst  = 1'b1;
         req_valid = 1'b0;
      end else if (d_next < ND) begin
         req_valid = 1'b1;
         if (!busy) begin
            req_write = d_write[d_next];
            req_addr  = d_addr[d_next];
            req_wdata = d_wdata[d_next];
            req_user  = d_user[d_next];
            o_w       = d_w[d_next];
            o_prd     = d_prd[d_next];
            o_slv     = d_slv[d_next];
            o_hold    = d_hold[d_next];
            o_didx    = d_next;
            d_next++;
         end else begin
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_user  = $urandom;
         end
      end else begin
         in_access = busy && elapsed >= 2 && elapsed <= 2 + k;
         if (lit_done && !rst_forced && cyc > 300 && in_access) begin
            core_rst   = 1'b1;
            rst_forced = 1'b1;
            rst_probe  = 1'b1;
         end else if (!(busy && cur_d >= 0) && $urandom_range(0, 299) == 0) begin
            core_rst = 1'b1;
         end
         req_valid = ($urandom_range(0, 2) != 0);
         req_write = 1'($urandom);
         req_addr  = $urandom;
         req_wdata = $urandom;
         req_user  = $urandom;
         r = $urandom_range(0, 9);
         if (r <= 5)      o_w = $urandom_range(0, 3);
         else if (r == 6) o_w = TO - 2;
         else if (r == 7) o_w = TO - 1;
         else if (r == 8) o_w = TO;
         else             o_w = $urandom_range(TO + 1, 30);
         o_prd  = $urandom;
         o_slv  = ($urandom_range(0, 3) == 0);
         o_hold = 0;
         o_didx = -1;
      end
      if (busy && cur_d >= 0) rsp_ready = (elapsed >= 3 + k + m_hold);
      else                    rsp_ready = ($urandom_range(0, 3) != 0);
      if (busy && elapsed >= 2 && elapsed <= 2 + k) begin
         PREADY  = ((elapsed - 2) == w_cur);
         PRDATA  = PREADY ? m_prd : $urandom;
         PSLVERR = PREADY ? m_slv : 1'($urandom);
      end else begin
         PREADY  = 1'($urandom);
         PRDATA  = $urandom;
         PSLVERR = 1'($urandom);
      end
   endtask

   initial begin
      core_rst  = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_user  = '0;
      rsp_ready = 1'b0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      busy = 1'b0; elapsed = 0; k = 0; w_cur = 0; m_hold = 0; cur_d = -1; acc_cyc = 0;
      m_write = 1'b0; m_err = 1'b0; m_to = 1'b0; m_slv = 1'b0; rsp_seen = 1'b0;
      m_addr = '0; m_wdata = '0; m_user = '0; m_rdata = '0; m_prd = '0;
      m_xfer = 0; m_errc = 0;
      o_w = 0; o_hold = 0; o_didx = -1; o_prd = '0; o_slv = 1'b0;
      d_next = 0; lit_done = 1'b0; rst_forced = 1'b0; rst_probe = 1'b0;
      $display("[TB] starting caliptra_apb_initiator bench");
      for (int i = 0; i < N_CYC; i++) begin
         @(negedge core_clk);
         cyc++;
         advanceModel();
         if (cyc == 3) begin
            checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
            checkOutput("reset_PSEL", 32'(PSEL), 32'h0);
            checkOutput("reset_PADDR", PADDR, 32'h0);
            checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
            checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
            checkOutput("reset_cnt_err", 32'(cnt_err), 32'h0);
         end
         compareAll();
         applyStimulus();
      end
      checkOutput("directed_completed", 32'(lit_done), 32'h1);
      checkOutput("midreset_exercised", 32'(rst_forced), 32'h1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
